// File: rtl/qe_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : qe_multi_channel
// Purpose  : N-channel quadrature encoder interface. Each channel synchronises
//            and (optionally) glitch-filters its A/B/I inputs, 4x-decodes A/B
//            into a modulo position counter with a turns counter, latches the
//            position on an index rising edge, measures the period between
//            counts, and flags illegal (double-bit) transitions. A shared
//            single-cycle register port reaches every channel.
// Macro    : QE_GLITCH_FILTER_EN - when defined, each input must be stable for
//            FILT_LEN cycles before it is accepted; when undefined the filter
//            is removed and FILT_LEN has no effect.
// Ports    : clk, reset (async, active-low)
//            async_QE_A/B/I [NUM_CH]  raw encoder inputs
//            reg_wr, reg_rd, reg_ch, reg_sel, wr_data  register access
//            rd_data, rd_valid        registered read response
//            irq [NUM_CH]             per-channel level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module qe_multi_channel #(
    parameter int NUM_CH   = 4,
    parameter int COUNT_W  = 32,
    parameter int SPEED_W  = 24,
    parameter int FILT_LEN = 4,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] async_QE_A,
    input  logic [NUM_CH-1:0] async_QE_B,
    input  logic [NUM_CH-1:0] async_QE_I,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [CH_W-1:0]   reg_ch,
    input  logic [2:0]        reg_sel,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] irq
);

    localparam logic [1:0]         S_WAIT  = 2'd0;
    localparam logic [1:0]         S_MEAS  = 2'd1;
    localparam logic [1:0]         S_STALL = 2'd2;
    localparam logic [SPEED_W-1:0] PER_MAX = '1;

    // Read view of every register of every channel: [channel][reg_sel]
    logic [NUM_CH-1:0][7:0][31:0] w_rd;
    logic                         w_ch_ok;
    logic [31:0]                  rd_data_q;
    logic                         rd_valid_q;

    assign w_ch_ok = (32'(reg_ch) < 32'(NUM_CH));

`ifndef QE_GLITCH_FILTER_EN
    logic [3:0] w_unused_filt;
    assign w_unused_filt = 4'(FILT_LEN);
`endif

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [2:0]         sync1_q, sync2_q;   // {I, B, A}
        logic [2:0]         filt;
        logic [1:0]         cur_ab, prev_ab_q;  // {A, B} after optional swap
        logic               i_prev_q;
        logic [COUNT_W-1:0] pos_q, pos_d, turns_q, turns_d, cpr_q, latch_q;
        logic [4:0]         cfg_q;
        logic [SPEED_W-1:0] speed_q, speed_d, per_q, per_d;
        logic [1:0]         st_q, st_d;
        logic               dir_q, err_q, seen_q;
        logic               fwd, bwd, en, up, step, err_evt, idx_rise, clr;
        logic               wr_ch, wr_pos, wr_turns;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= {async_QE_I[n], async_QE_B[n], async_QE_A[n]};
                sync2_q <= sync1_q;
            end
        end

`ifdef QE_GLITCH_FILTER_EN
        for (genvar s = 0; s < 3; s++) begin : g_filt
            logic [3:0] cnt_q;
            logic       val_q;
            // Counts consecutive cycles the synchronised input disagrees with
            // the accepted value; any agreement restarts the count.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                    val_q <= 1'b0;
                end else if (sync2_q[s] == val_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == 4'(FILT_LEN - 1)) begin
                    val_q <= sync2_q[s];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
            assign filt[s] = val_q;
        end
`else
        assign filt = sync2_q;
`endif

        assign en       = cfg_q[0];
        assign cur_ab   = cfg_q[1] ? {filt[1], filt[0]} : {filt[0], filt[1]};
        assign idx_rise = filt[2] & ~i_prev_q;
        assign wr_ch    = reg_wr && (reg_ch == CH_W'(n));
        assign wr_pos   = wr_ch && (reg_sel == 3'd0);
        assign wr_turns = wr_ch && (reg_sel == 3'd1);
        assign clr      = reg_rd && (reg_ch == CH_W'(n)) && (reg_sel == 3'd5);

        // Forward sequence 00 -> 10 -> 11 -> 01 -> 00 on {A, B}
        always_comb begin
            fwd = 1'b0;
            bwd = 1'b0;
            case ({prev_ab_q, cur_ab})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
                4'b1000, 4'b1110, 4'b0111, 4'b0001: bwd = 1'b1;
                default: ;
            endcase
        end

        assign err_evt = en && ((prev_ab_q ^ cur_ab) == 2'b11);
        assign step    = en && (fwd || bwd);
        assign up      = fwd ^ cfg_q[2];

        always_comb begin
            pos_d   = pos_q;
            turns_d = turns_q;
            if (step) begin
                if (cpr_q == '0) begin
                    pos_d = up ? pos_q + COUNT_W'(1) : pos_q - COUNT_W'(1);
                end else if (up) begin
                    if (pos_q == cpr_q - COUNT_W'(1)) begin
                        pos_d   = '0;
                        turns_d = turns_q + COUNT_W'(1);
                    end else begin
                        pos_d = pos_q + COUNT_W'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d   = cpr_q - COUNT_W'(1);
                        turns_d = turns_q - COUNT_W'(1);
                    end else begin
                        pos_d = pos_q - COUNT_W'(1);
                    end
                end
            end
            // Index clear discards the whole same-cycle count
            if (idx_rise && cfg_q[3]) begin
                pos_d   = '0;
                turns_d = turns_q;
            end
            if (wr_pos)   pos_d   = wr_data[COUNT_W-1:0];
            if (wr_turns) turns_d = wr_data[COUNT_W-1:0];
        end

        // Speed FSM: state register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) st_q <= S_WAIT;
            else        st_q <= st_d;
        end

        // Speed FSM: next state
        always_comb begin
            st_d = st_q;
            if (!en) begin
                st_d = S_WAIT;
            end else begin
                case (st_q)
                    S_WAIT:  if (step) st_d = S_MEAS;
                    S_MEAS:  if (!step && (per_q == PER_MAX - SPEED_W'(1))) st_d = S_STALL;
                    S_STALL: if (step) st_d = S_MEAS;
                    default: st_d = S_WAIT;
                endcase
            end
        end

        // Speed FSM: period counter and speed result
        always_comb begin
            per_d   = per_q;
            speed_d = speed_q;
            if (!en) begin
                per_d = '0;
            end else begin
                case (st_q)
                    S_WAIT: if (step) per_d = SPEED_W'(1);
                    S_MEAS: begin
                        if (step) begin
                            speed_d = per_q;
                            per_d   = SPEED_W'(1);
                        end else begin
                            per_d = per_q + SPEED_W'(1);
                            if (per_q == PER_MAX - SPEED_W'(1)) speed_d = PER_MAX;
                        end
                    end
                    // A count after a stall restarts timing without a result
                    S_STALL: if (step) per_d = SPEED_W'(1);
                    default: per_d = '0;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                prev_ab_q <= '0;
                i_prev_q  <= 1'b0;
                pos_q     <= '0;
                turns_q   <= '0;
                cpr_q     <= '0;
                cfg_q     <= '0;
                latch_q   <= '0;
                speed_q   <= '0;
                per_q     <= '0;
                dir_q     <= 1'b0;
                err_q     <= 1'b0;
                seen_q    <= 1'b0;
            end else begin
                prev_ab_q <= cur_ab;
                i_prev_q  <= filt[2];
                pos_q     <= pos_d;
                turns_q   <= turns_d;
                speed_q   <= speed_d;
                per_q     <= per_d;
                if (wr_ch && (reg_sel == 3'd2)) cpr_q <= wr_data[COUNT_W-1:0];
                if (wr_ch && (reg_sel == 3'd3)) cfg_q <= wr_data[4:0];
                if (step)     dir_q   <= up;
                if (idx_rise) latch_q <= pos_q;
                // A new event in the clearing cycle wins over the clear
                err_q  <= err_evt  | (err_q  & ~clr);
                seen_q <= idx_rise | (seen_q & ~clr);
            end
        end

        assign w_rd[n][0] = 32'(pos_q);
        assign w_rd[n][1] = 32'(turns_q);
        assign w_rd[n][2] = 32'(cpr_q);
        assign w_rd[n][3] = 32'(cfg_q);
        assign w_rd[n][4] = 32'(speed_q);
        assign w_rd[n][5] = {25'd0, (st_q == S_STALL), seen_q, err_q, dir_q,
                             filt[2], cur_ab[0], cur_ab[1]};
        assign w_rd[n][6] = 32'(latch_q);
        assign w_rd[n][7] = 32'd0;
        assign irq[n]     = cfg_q[4] & (err_q | seen_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= reg_rd;
            rd_data_q  <= (reg_rd && w_ch_ok) ? w_rd[reg_ch][reg_sel] : 32'd0;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_qe_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_qe_multi_channel
// Purpose  : Directed self-checking bench for qe_multi_channel (3 channels,
//            32-bit counters, 8-bit speed counter, FILT_LEN 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qe_multi_channel;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [2:0]  qa       = '0;
    logic [2:0]  qb       = '0;
    logic [2:0]  qi       = '0;
    logic        reg_wr   = 1'b0;
    logic        reg_rd   = 1'b0;
    logic [1:0]  reg_ch   = '0;
    logic [2:0]  reg_sel  = '0;
    logic [31:0] wr_data  = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [2:0]  irq;

    int total = 0;
    int bad   = 0;
    int ph[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    qe_multi_channel #(
        .NUM_CH  (3),
        .COUNT_W (32),
        .SPEED_W (8),
        .FILT_LEN(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .async_QE_A(qa),
        .async_QE_B(qb),
        .async_QE_I(qi),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_ch    (reg_ch),
        .reg_sel   (reg_sel),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [2:0] sel, input logic [31:0] d);
        @(negedge clk);
        reg_wr = 1'b1; reg_ch = ch; reg_sel = sel; wr_data = d;
        @(negedge clk);
        reg_wr = 1'b0;
    endtask

    // Read and compare {rd_valid, rd_data}
    task automatic rdchk(input string tag, input logic [1:0] ch, input logic [2:0] sel,
                         input logic [31:0] exp);
        @(negedge clk);
        reg_rd = 1'b1; reg_ch = ch; reg_sel = sel;
        @(negedge clk);
        reg_rd = 1'b0;
        chk(tag, {rd_valid, rd_data}, {1'b1, exp});
    endtask

    // One quadrature step, held stable 20 cycles; {A,B} phases 00,10,11,01
    task automatic qstep(input int ch, input bit fwd, input bit idx);
        @(negedge clk);
        ph[ch] = fwd ? (ph[ch] + 1) % 4 : (ph[ch] + 3) % 4;
        qa[ch] = (ph[ch] == 1) || (ph[ch] == 2);
        qb[ch] = (ph[ch] >= 2);
        if (idx) qi[ch] = 1'b1;
        repeat (19) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_rd", {rd_valid, rd_data}, 64'd0);
        chk("reset_irq", irq, 64'd0);
        reset = 1'b1;
        rdchk("rst_pos0", 0, 0, 32'd0);
        rdchk("rst_status0", 0, 5, 32'd0);
        rdchk("rst_speed0", 0, 4, 32'd0);

        // Simultaneous read and write returns the pre-write value
        @(negedge clk);
        reg_wr = 1'b1; reg_rd = 1'b1; reg_ch = 0; reg_sel = 0; wr_data = 32'h1234;
        @(negedge clk);
        reg_wr = 1'b0; reg_rd = 1'b0;
        chk("rw_pre", {rd_valid, rd_data}, {1'b1, 32'h0});
        rdchk("rw_post", 0, 0, 32'h1234);

        // cpr=8, ten forward steps: 10 mod 8 = 2, one turn, period 20
        wr(0, 0, 32'd0);
        wr(0, 2, 32'd8);
        wr(0, 3, 32'd1);
        repeat (10) qstep(0, 1, 0);
        rdchk("fwd_pos", 0, 0, 32'd2);
        rdchk("fwd_turns", 0, 1, 32'd1);
        rdchk("fwd_speed", 0, 4, 32'd20);
        rdchk("fwd_status", 0, 5, 32'h0B);

        // No edges long enough to saturate the 8-bit period counter
        repeat (300) @(negedge clk);
        rdchk("stall_speed", 0, 4, 32'd255);
        rdchk("stall_status", 0, 5, 32'h4B);
        qstep(0, 1, 0);
        rdchk("unstall_status", 0, 5, 32'h0A);
        rdchk("unstall_speed", 0, 4, 32'd255);
        rdchk("unstall_pos", 0, 0, 32'd3);

        // cpr=0, one reverse step from 0 wraps to all ones
        wr(2, 3, 32'd1);
        wr(2, 0, 32'd0);
        qstep(2, 0, 0);
        rdchk("rev_pos", 2, 0, 32'hFFFF_FFFF);
        rdchk("rev_turns", 2, 1, 32'd0);
        rdchk("rev_status", 2, 5, 32'h02);

        // CONFIG truncation, then index with clear coinciding with a +1 step
        wr(2, 3, 32'hFFFF_FFE9);
        rdchk("cfg_trunc", 2, 3, 32'h09);
        wr(2, 0, 32'd4);
        qstep(2, 1, 0);
        rdchk("idx_pre_pos", 2, 0, 32'd5);
        qstep(2, 1, 1);
        qi[2] = 1'b0;
        repeat (20) @(negedge clk);
        rdchk("idx_latch", 2, 6, 32'd5);
        rdchk("idx_pos", 2, 0, 32'd0);
        rdchk("idx_status", 2, 5, 32'h29);
        chk("idx_irq_off", irq, 64'd0);

        // Glitch rejection and illegal transitions on channel 1
        wr(1, 3, 32'h11);
`ifdef QE_GLITCH_FILTER_EN
        @(negedge clk);
        qa[1] = 1'b1;
        repeat (3) @(negedge clk);
        qa[1] = 1'b0;
        repeat (20) @(negedge clk);
        rdchk("glitch_pos", 1, 0, 32'd0);
        rdchk("glitch_status", 1, 5, 32'd0);
`endif
        @(negedge clk);
        qa[1] = 1'b1; qb[1] = 1'b1;
        repeat (20) @(negedge clk);
        chk("err_irq", irq, 64'b010);
        qa[1] = 1'b0; qb[1] = 1'b0;
        repeat (20) @(negedge clk);
        rdchk("err_pos", 1, 0, 32'd0);
        rdchk("err_status1", 1, 5, 32'h10);
        rdchk("err_status2", 1, 5, 32'h00);
        chk("err_irq_clr", irq, 64'd0);

        // Asynchronous reset in the middle of a read response
        @(negedge clk);
        qa[1] = 1'b1; qb[1] = 1'b1;
        repeat (20) @(negedge clk);
        chk("pre_rst_irq", irq, 64'b010);
        reg_rd = 1'b1; reg_ch = 0; reg_sel = 0;
        @(posedge clk);
        #2;
        chk("pre_rst_rdv", {rd_valid, rd_data}, {1'b1, 32'd3});
        reset = 1'b0;
        #1;
        chk("async_rst", {irq, rd_valid, rd_data}, 64'd0);
        @(negedge clk);
        reg_rd = 1'b0;
        reset  = 1'b1;
        rdchk("post_rst_pos", 0, 0, 32'd0);
        rdchk("post_rst_cfg", 1, 3, 32'd0);
        rdchk("bad_channel", 3, 0, 32'd0);
        rdchk("reserved", 0, 7, 32'd0);
        chk("post_rst_irq", irq, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
